// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage: PC, single-outstanding fetch, (pc, inst) FIFO
// Presents the FIFO head to IF/ID and handles branch redirect with delay-slot retention.
module if_fetch #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_gnt,
  input  logic        inst_rvalid,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {S_RUN, S_DS_FETCH} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   r_btarget;
  logic [31:0]   r_issued_pc;
  logic [31:0]   r_fifo_pc   [DEPTH];
  logic [31:0]   r_fifo_inst [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_outstanding;
  logic          r_drop;

  logic          w_nonempty;
  logic          w_pop;
  logic          w_branch;
  logic          w_rsp;
  logic          w_push;
  logic          w_fire;
  logic          w_flush_all;
  logic          w_keep_head;
  logic          w_case_d;
  logic          w_discard;
  logic          w_room;
  logic [CW:0]   w_level;
  logic [CW:0]   w_cap;
  logic          w_unused;

  assign w_unused = &{1'b0, stall[5:3]};

  always_comb begin
    w_nonempty  = (r_count != '0);
    w_pop       = w_nonempty && !stall[1];
    w_branch    = branch_flag_i && !stall[2];
    w_rsp       = inst_rvalid && r_outstanding;
    w_flush_all = w_branch && w_pop;
    w_keep_head = w_branch && !w_pop && w_nonempty;
    w_case_d    = w_branch && !w_nonempty && !r_outstanding;
    w_discard   = w_flush_all || w_keep_head;
    w_push      = w_rsp && !r_drop && !w_discard;
    // A new request must still find a slot next cycle even if IF stalls then.
    w_level     = {1'b0, r_count} + {{CW{1'b0}}, w_push} + (CW+1)'(1);
    w_cap       = (CW+1)'(DEPTH) + {{CW{1'b0}}, w_pop};
    w_room      = (w_level <= w_cap);
    inst_req    = rst && !stall[0] && !w_branch && (!r_outstanding || inst_rvalid) && w_room;
    inst_addr   = r_pc;
    w_fire      = inst_req && inst_gnt;
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:      if (w_case_d) w_state_nxt = S_DS_FETCH;
      S_DS_FETCH: if (w_fire)   w_state_nxt = S_RUN;
      default:    w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_RUN;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_btarget     <= '0;
      r_issued_pc   <= '0;
      r_outstanding <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      // Case D defers the redirect until the delay-slot fetch is granted.
      if (w_branch && !w_case_d) r_pc <= branch_target_address_i;
      else if (w_fire)           r_pc <= (r_state == S_DS_FETCH) ? r_btarget : r_pc + 32'd4;
      if (w_case_d) r_btarget <= branch_target_address_i;
      if (w_fire) begin
        r_issued_pc   <= r_pc;
        r_outstanding <= 1'b1;
      end else if (w_rsp) begin
        r_outstanding <= 1'b0;
      end
      if (w_discard && r_outstanding && !inst_rvalid) r_drop <= 1'b1;
      else if (w_rsp)                                  r_drop <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush_all) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_keep_head) begin
      r_wr_ptr <= r_rd_ptr + AW'(1);
      r_count  <= CW'(1);
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_issued_pc;
      r_fifo_inst[r_wr_ptr] <= inst_rdata;
    end
  end

  assign if_pc       = w_nonempty ? r_fifo_pc[r_rd_ptr]   : 32'h0;
  assign if_inst     = w_nonempty ? r_fifo_inst[r_rd_ptr] : 32'h0;
  assign stallreq_if = !w_nonempty;

endmodule
